// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared types and helpers for the sequential multiply/divide unit.
//   - op_e    : operation code as presented on the op port
//   - state_e : control FSM states (IDLE -> RUN -> FIX -> IDLE)
//   - twos_neg: two's complement negate on a wide vector. Callers size-cast
//               the argument up and the result back down to their own width.
//               Truncating a wide negate gives the same low bits as a negate
//               done at the narrow width. The widest operand handled is
//               NEG_MAX_W bits, so the unit supports WIDTH up to 64.
//   Optional divider macro used elsewhere: MULDIV_DIV_EN
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam int NEG_MAX_W = 128;

    function automatic logic [NEG_MAX_W-1:0] twos_neg(input logic [NEG_MAX_W-1:0] v);
        return ~v + {{(NEG_MAX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//   One combinational radix-2 iteration on the {hi,lo} accumulator.
//   Multiply: shift-add. The multiplier sits in lo. Bit 0 selects whether the
//             multiplicand is added into hi. The W+1 bit sum then shifts right.
//   Divide (MULDIV_DIV_EN only): restoring step. The dividend sits in lo and
//             the partial remainder in hi. The pair shifts left and a trial
//             subtract is done on the top W+1 bits. The inverted borrow
//             becomes the next quotient bit.
//   Ports:
//     is_div   in  1        divide step select (present only with MULDIV_DIV_EN)
//     acc      in  2*WIDTH  current {hi,lo} accumulator
//     mcand    in  WIDTH    multiplicand magnitude / divisor magnitude
//     acc_next out 2*WIDTH  accumulator after one iteration
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic                 is_div,
`endif
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     mcand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] mul_next_s;

    // shift-add multiply iteration
    always_comb begin
        sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        if (acc[0]) begin
            mul_next_s = {sum_s, acc[WIDTH-1:1]};
        end else begin
            mul_next_s = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     trial_s;
    logic [2*WIDTH-1:0] div_next_s;

    // restoring divide iteration. The remainder stays below the divisor, so
    // bit WIDTH of the trial difference is a reliable borrow flag.
    always_comb begin
        rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
        trial_s  = rem_sh_s - {1'b0, mcand};
        if (!trial_s[WIDTH]) begin
            div_next_s = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // select the iteration matching the operation in flight
    always_comb begin
        if (is_div) begin
            acc_next = div_next_s;
        end else begin
            acc_next = mul_next_s;
        end
    end
`else
    // only the multiply iteration exists in this build
    always_comb begin
        acc_next = mul_next_s;
    end
`endif

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Multi-cycle integer multiply/divide unit with a start/busy/done handshake.
//   Only one operation is in flight at a time. Signed operands are converted
//   to magnitudes at acceptance. The unsigned core runs WIDTH iterations. The
//   sign is restored in the FIX cycle, which also writes hi/lo.
//   Optional feature macro: MULDIV_DIV_EN (restoring divider for DIV/DIVU).
//   Without it, DIV/DIVU complete in FIX with hi/lo untouched.
//   Ports:
//     clk      in  1      clock, rising edge
//     reset    in  1      synchronous active-high reset, overrides everything
//     start    in  1      request, accepted only in IDLE
//     op       in  2      0=MULT 1=MULTU 2=DIV 3=DIVU, sampled with start
//     a, b     in  WIDTH  operands, sampled with start
//     busy     out 1      high from acceptance until the edge raising done
//     done     out 1      single-cycle completion pulse
//     hi, lo   out WIDTH  product high/low, or remainder/quotient
//     div_zero out 1      divide by zero flag, cleared on next acceptance
// -----------------------------------------------------------------------------
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int ACC_W = 2 * WIDTH;

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   acc_r;
    logic [WIDTH-1:0]   mcand_r;
    logic               is_div_r;
    logic               neg_res_r;

    op_e                op_in_s;
    logic               is_signed_s;
    logic               is_div_in_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [ACC_W-1:0]   step_s;
    logic [ACC_W-1:0]   prod_neg_s;

`ifdef MULDIV_DIV_EN
    logic               neg_rem_r;
    logic               dz_r;
    logic [WIDTH-1:0]   quo_neg_s;
    logic [WIDTH-1:0]   rem_neg_s;
`endif

    // decode the incoming request and take operand magnitudes for signed ops
    always_comb begin
        op_in_s     = op_e'(op);
        is_signed_s = (op_in_s == OP_MULT) || (op_in_s == OP_DIV);
        is_div_in_s = (op_in_s == OP_DIV) || (op_in_s == OP_DIVU);
        if (is_signed_s && a[WIDTH-1]) begin
            mag_a_s = WIDTH'(twos_neg(NEG_MAX_W'(a)));
        end else begin
            mag_a_s = a;
        end
        if (is_signed_s && b[WIDTH-1]) begin
            mag_b_s = WIDTH'(twos_neg(NEG_MAX_W'(b)));
        end else begin
            mag_b_s = b;
        end
    end

    // negated forms of the finished accumulator for sign correction in FIX
    always_comb begin
        prod_neg_s = ACC_W'(twos_neg(NEG_MAX_W'(acc_r)));
`ifdef MULDIV_DIV_EN
        quo_neg_s  = WIDTH'(twos_neg(NEG_MAX_W'(acc_r[WIDTH-1:0])));
        rem_neg_s  = WIDTH'(twos_neg(NEG_MAX_W'(acc_r[ACC_W-1:WIDTH])));
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
        .is_div   (is_div_r),
`endif
        .acc      (acc_r),
        .mcand    (mcand_r),
        .acc_next (step_s)
    );

    // control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= {WIDTH{1'b0}};
            lo        <= {WIDTH{1'b0}};
            div_zero  <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        div_zero  <= 1'b0;
                        is_div_r  <= is_div_in_s;
                        acc_r     <= {{WIDTH{1'b0}}, mag_a_s};
                        mcand_r   <= mag_b_s;
                        neg_res_r <= is_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt_r     <= CNT_W'(WIDTH);
                        if (is_div_in_s) begin
`ifdef MULDIV_DIV_EN
                            neg_rem_r <= is_signed_s && a[WIDTH-1];
                            if (b == {WIDTH{1'b0}}) begin
                                // keep the raw dividend for hi and skip the iterations
                                dz_r    <= 1'b1;
                                acc_r   <= {{WIDTH{1'b0}}, a};
                                state_r <= S_FIX;
                            end else begin
                                dz_r    <= 1'b0;
                                state_r <= S_RUN;
                            end
`else
                            state_r <= S_FIX;
`endif
                        end else begin
`ifdef MULDIV_DIV_EN
                            dz_r <= 1'b0;
`endif
                            state_r <= S_RUN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_FIX: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= S_IDLE;
                    if (!is_div_r) begin
                        if (neg_res_r) begin
                            {hi, lo} <= prod_neg_s;
                        end else begin
                            {hi, lo} <= acc_r;
                        end
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (dz_r) begin
                            hi       <= acc_r[WIDTH-1:0];
                            lo       <= {WIDTH{1'b1}};
                            div_zero <= 1'b1;
                        end else begin
                            lo       <= neg_res_r ? quo_neg_s : acc_r[WIDTH-1:0];
                            hi       <= neg_rem_r ? rem_neg_s : acc_r[ACC_W-1:WIDTH];
                            div_zero <= 1'b0;
                        end
`else
                        hi <= hi;
                        lo <= lo;
`endif
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
//   Self-checking bench for muldiv_seq (WIDTH=32). Expected results come from
//   64-bit integer arithmetic on the operands. Expected latencies come from
//   the documented cycle behaviour. Directed cases are followed by randomized
//   operations, some of them issued back-to-back in the done cycle.
//   Honours MULDIV_DIV_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dz;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: new architectural hi/lo/div_zero and latency (edges after acceptance)
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, up;
        logic [63:0]     t;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        lat = 33;
        case (o)
            2'd0: begin
                t = sx * sy;
                m_hi = t[63:32]; m_lo = t[31:0]; m_dz = 1'b0;
            end
            2'd1: begin
                up = ux * uy; t = up;
                m_hi = t[63:32]; m_lo = t[31:0]; m_dz = 1'b0;
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (y == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = x; m_dz = 1'b1; lat = 1;
                end else if (o == 2'd2) begin
                    sq = sx / sy; sr = sx % sy;
                    t = sq; m_lo = t[31:0];
                    t = sr; m_hi = t[31:0];
                    m_dz = 1'b0;
                end else begin
                    t = ux / uy; m_lo = t[31:0];
                    t = ux % uy; m_hi = t[31:0];
                    m_dz = 1'b0;
                end
`else
                m_dz = 1'b0;
                lat  = 1;
`endif
            end
        endcase
    endtask

    // Issue one operation and check handshake timing and results.
    // b2b_in : drive start right now (we are in the previous done cycle)
    // hammer : keep start high with changing operands while busy
    // chain_out : return in the done cycle so the next op can go back-to-back
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit hammer, input bit b2b_in, input bit chain_out);
        int lat;
        int edges;
        bit busy_ok;
        model(o, x, y, lat);
        if (!b2b_in) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = hammer;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        edges = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
            if (hammer) begin
                a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
            end
        end
        start = 1'b0;
        check("latency", 64'(edges), 64'(lat));
        check("busy_throughout", {63'd0, busy_ok}, 64'd1);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("hi", {32'd0, hi}, {32'd0, m_hi});
        check("lo", {32'd0, lo}, {32'd0, m_lo});
        check("div_zero", {63'd0, div_zero}, {63'd0, m_dz});
        if (!chain_out) begin
            @(posedge clk); #1;
            check("done_single_pulse", {63'd0, done}, 64'd0);
            check("idle_not_busy", {63'd0, busy}, 64'd0);
            check("hi_hold", {32'd0, hi}, {32'd0, m_hi});
            check("lo_hold", {32'd0, lo}, {32'd0, m_lo});
        end
    endtask

    function automatic logic [31:0] pick_operand(input int sel);
        case (sel)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit chain;
        bit next_chain;
        int lat_unused;
        reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_div_zero", {63'd0, div_zero}, 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("no_done_without_start", {63'd0, done}, 64'd0);

        // directed cases
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        run_op(2'd0, 32'h1234_5678, 32'hFEDC_BA98, 1'b1, 1'b0, 1'b0);

        // reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd123; b = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", {63'd0, done}, 64'd0);

        run_op(2'd0, 32'd6, 32'd7, 1'b0, 1'b0, 1'b1);
        // back-to-back: second op accepted in the done cycle
        run_op(2'd1, 32'd100, 32'd3, 1'b0, 1'b1, 1'b0);
        run_op(2'd0, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
        run_op(2'd2, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        run_op(2'd3, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op(2'd1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);

        // randomized operations, some chained back-to-back
        chain = 1'b0;
        for (int i = 0; i < 40; i++) begin
            next_chain = ($urandom_range(0, 3) == 0);
            run_op(2'($urandom_range(0, 3)),
                   pick_operand($urandom_range(0, 7)),
                   pick_operand($urandom_range(0, 7)),
                   ($urandom_range(0, 5) == 0), chain, next_chain);
            chain = next_chain;
        end
        if (chain) begin
            @(posedge clk); #1;
            check("final_done_pulse", {63'd0, done}, 64'd0);
        end
        model(2'd1, 32'd0, 32'd0, lat_unused);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
